// File: rtl/mem_copy_engine.sv
// mem_copy_engine -- streaming block copy between two memory ports.
//
// Copies len words from [src_base, src_base+len) on the source read port to
// [dst_base, dst_base+len) on the destination write port, in ascending order.
// One read is issued per cycle. Each write is aligned combinationally with
// the matching rd_data, which arrives READ_LATENCY cycles after its read.
// Addresses wrap modulo 2^ADDR_W.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            single-cycle request, sampled only in IDLE
//   src_base         first source word address
//   dst_base         first destination word address
//   len              number of words (0 completes immediately)
//   data_width       precision tag, latched at start
//   busy             high while reads are issued and returns are draining
//   done             one-cycle pulse after the last write
//   rd_en, rd_addr   source read request
//   rd_data_width    latched precision tag for the source port
//   rd_data          source data, valid READ_LATENCY cycles after rd_en
//   wr_en            destination write enable
//   wr_chip_en       destination chip enable (same as wr_en)
//   wr_addr, wr_data destination write address and data
//   wr_data_width    latched precision tag for the destination port

package mem_copy_pkg;
    typedef enum logic [1:0] {
        HALF   = 2'd0,
        SINGLE = 2'd1,
        DOUBLE = 2'd2
    } DataWidth_t;
endpackage

module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int LEN_W        = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  len,
    input  DataWidth_t        data_width,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output DataWidth_t        rd_data_width,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic              wr_chip_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output DataWidth_t        wr_data_width
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    DataWidth_t        dw_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  retire_cnt;

    // One valid bit per outstanding read; bit READ_LATENCY-1 lines up with
    // the cycle in which the memory presents that read's data.
    logic [READ_LATENCY-1:0] vld_p;
    logic                    head;

    assign head = vld_p[READ_LATENCY-1];

    // State, latched request and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            dw_q       <= HALF;
            issue_cnt  <= '0;
            retire_cnt <= '0;
            vld_p      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                src_q      <= src_base;
                dst_q      <= dst_base;
                len_q      <= len;
                dw_q       <= data_width;
                issue_cnt  <= '0;
                retire_cnt <= '0;
            end else begin
                if (rd_en) begin
                    issue_cnt <= issue_cnt + LEN_W'(1);
                end
                if (head) begin
                    retire_cnt <= retire_cnt + LEN_W'(1);
                end
            end
            vld_p[0] <= rd_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Next state and control outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (issue_cnt == len_q - LEN_W'(1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // The last write always lands here: it trails the last
                // read by at least one cycle.
                if (head && retire_cnt == len_q - LEN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address/data buses are forced to zero when their strobe is low so the
    // ports idle at their reset values.
    assign rd_addr       = rd_en ? src_q + ADDR_W'(issue_cnt) : '0;
    assign wr_en         = head;
    assign wr_chip_en    = head;
    assign wr_addr       = head ? dst_q + ADDR_W'(retire_cnt) : '0;
    assign wr_data       = head ? rd_data : '0;
    assign rd_data_width = dw_q;
    assign wr_data_width = dw_q;

endmodule
